// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings, defaults and sizing helpers for the fetch/load-store RAM port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned BUS_64 = 64;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    localparam logic [63:0] RAM_BASE_DEFAULT  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] RAM_WORDS_DEFAULT = 64'h0000_0000_0800_0000;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    typedef struct packed {
        grant_e      grant;
        logic        we;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        err;
    } req_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // An access needs a second beat when its bytes spill past the 8-byte word.
    function automatic logic two_beats(input logic [2:0] off, input logic [1:0] sz);
        return ({1'b0, off} + size_bytes(sz)) > 4'd8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_align.sv
// Combinational lane steering: write data/mask placement across two words and load extraction/extension.
module mem_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] hi_i,
    input  logic [63:0] lo_i,
    output logic [63:0] w1_o,
    output logic [63:0] w2_o,
    output logic [63:0] m1_o,
    output logic [63:0] m2_o,
    output logic [63:0] rdata_o
);

    logic [6:0]   sh_s;
    logic [127:0] wshift_s;
    logic [127:0] mshift_s;
    logic [63:0]  r_s;

    assign sh_s = {1'b0, off_i, 3'b000};

    // Place sized store data and its mask, then pull the addressed bytes out of {hi,lo}.
    always_comb begin
        wshift_s = {64'd0, wdata_i & byte_mask(funct3_i[1:0])} << sh_s;
        mshift_s = {64'd0, byte_mask(funct3_i[1:0])} << sh_s;
        r_s      = 64'({hi_i, lo_i} >> sh_s);
    end

    assign w1_o = wshift_s[63:0];
    assign w2_o = wshift_s[127:64];
    assign m1_o = mshift_s[63:0];
    assign m2_o = mshift_s[127:64];

    // Truncate to the access size, then sign- or zero-extend.
    always_comb begin
        case (funct3_i)
            FUNCT3_LB:  rdata_o = {{56{r_s[7]}},  r_s[7:0]};
            FUNCT3_LH:  rdata_o = {{48{r_s[15]}}, r_s[15:0]};
            FUNCT3_LW:  rdata_o = {{32{r_s[31]}}, r_s[31:0]};
            FUNCT3_LBU: rdata_o = {56'd0, r_s[7:0]};
            FUNCT3_LHU: rdata_o = {48'd0, r_s[15:0]};
            FUNCT3_LWU: rdata_o = {32'd0, r_s[31:0]};
            default:    rdata_o = r_s;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit word-indexed RAM port between instruction fetch and load/store,
// splitting word-crossing accesses into two beats.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [63:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter logic [63:0] RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [BUS_64-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BUS_64-1:0] d_addr,
    input  logic [2:0]        d_funct3,
    input  logic [BUS_64-1:0] d_wdata,
    output logic              d_ack,
    output logic [BUS_64-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [BUS_64-1:0] ram_idx,
    output logic [BUS_64-1:0] ram_wdata,
    output logic [BUS_64-1:0] ram_wmask,
    input  logic [BUS_64-1:0] ram_rdata
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_B1   = 2'b01;
    localparam logic [1:0] ST_B2   = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    logic [1:0]  state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    req_t        req_q, req_d;
    logic [63:0] lo_q, lo_d;

    grant_e      sel_s;
    req_t        new_req_s;
    logic [64:0] rel_s;
    logic [64:0] last_rel_s;
    logic [63:0] idx_s;
    logic        two_beat_s;
    logic [63:0] hi_s, lo_sel_s;
    logic [63:0] w1_s, w2_s, m1_s, m2_s, ext_s;

    // Pick a requester and range-check its access before it is latched.
    always_comb begin
        if (if_req && d_req) begin
            sel_s = (last_grant_q == GRANT_IF) ? GRANT_D : GRANT_IF;
        end else if (d_req) begin
            sel_s = GRANT_D;
        end else begin
            sel_s = GRANT_IF;
        end
        new_req_s.grant = sel_s;
        if (sel_s == GRANT_D) begin
            new_req_s.addr   = d_addr;
            new_req_s.we     = d_we;
            new_req_s.funct3 = d_funct3;
            new_req_s.wdata  = d_wdata;
        end else begin
            new_req_s.addr   = if_addr;
            new_req_s.we     = 1'b0;
            new_req_s.funct3 = FUNCT3_LWU;
            new_req_s.wdata  = 64'd0;
        end
        rel_s      = {1'b0, new_req_s.addr} - {1'b0, RAM_BASE};
        last_rel_s = rel_s + {61'd0, size_bytes(new_req_s.funct3[1:0])} - 65'd1;
        new_req_s.err = (new_req_s.addr < RAM_BASE) ||
                        ((last_rel_s >> 3) >= {1'b0, RAM_WORDS});
    end

    assign idx_s      = (req_q.addr - RAM_BASE) >> 3;
    assign two_beat_s = two_beats(req_q.addr[2:0], req_q.funct3[1:0]);
    assign hi_s       = two_beat_s ? ram_rdata : 64'd0;
    assign lo_sel_s   = two_beat_s ? lo_q : ram_rdata;

    mem_align u_align (
        .off_i    (req_q.addr[2:0]),
        .funct3_i (req_q.funct3),
        .wdata_i  (req_q.wdata),
        .hi_i     (hi_s),
        .lo_i     (lo_sel_s),
        .w1_o     (w1_s),
        .w2_o     (w2_s),
        .m1_o     (m1_s),
        .m2_o     (m2_s),
        .rdata_o  (ext_s)
    );

    // Access sequencing; B2 captures the first beat's read data.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        lo_d         = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    req_d   = new_req_s;
                    state_d = new_req_s.err ? ST_DONE : ST_B1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_B1:   state_d = two_beat_s ? ST_B2 : ST_DONE;
            ST_B2: begin
                lo_d    = ram_rdata;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_grant_d = req_q.grant;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched request; reset abandons any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_IF;
            req_q        <= {$bits(req_t){1'b0}};
            lo_q         <= 64'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            lo_q         <= lo_d;
        end
    end

    // Outputs decode from the registered state so reset silences them at once.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = 64'd0;
        ram_wdata = 64'd0;
        ram_wmask = 64'd0;
        if_ack    = 1'b0;
        if_err    = 1'b0;
        if_rdata  = 32'd0;
        d_ack     = 1'b0;
        d_err     = 1'b0;
        d_rdata   = 64'd0;
        case (state_q)
            ST_B1: begin
                ram_en    = 1'b1;
                ram_we    = req_q.we;
                ram_idx   = idx_s;
                ram_wdata = w1_s;
                ram_wmask = req_q.we ? m1_s : 64'd0;
            end
            ST_B2: begin
                ram_en    = 1'b1;
                ram_we    = req_q.we;
                ram_idx   = idx_s + 64'd1;
                ram_wdata = w2_s;
                ram_wmask = req_q.we ? m2_s : 64'd0;
            end
            ST_DONE: begin
                if (req_q.grant == GRANT_D) begin
                    d_ack   = 1'b1;
                    d_err   = req_q.err;
                    d_rdata = (req_q.err || req_q.we) ? 64'd0 : ext_s;
                end else begin
                    if_ack   = 1'b1;
                    if_err   = req_q.err;
                    if_rdata = req_q.err ? 32'd0 : ext_s[31:0];
                end
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench: a byte-array reference memory predicts every ack, a word RAM model serves the DUT.
module tb_mem_port_arbiter;

    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
    localparam int          NWORDS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack, if_err, d_req, d_we, d_ack, d_err;
    logic        ram_en, ram_we;
    logic [63:0] if_addr, d_addr, d_wdata, d_rdata;
    logic [31:0] if_rdata;
    logic [2:0]  d_funct3;
    logic [63:0] ram_idx, ram_wdata, ram_wmask, ram_rdata;

    mem_port_arbiter #(.RAM_BASE(BASE), .RAM_WORDS(64'd16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_idx(ram_idx), .ram_wdata(ram_wdata),
        .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_d; logic [63:0] rdata; bit err; int cyc; } exp_t;
    typedef struct { logic [63:0] idx; bit we; logic [63:0] wdata; logic [63:0] wmask; } beat_t;
    exp_t  expq[$];
    beat_t beatq[$];
    exp_t  mon_e;

    logic [63:0] ram [NWORDS];
    logic [7:0]  refb [NWORDS*8];
    bit          lg_d_last;
    logic        poke_en;
    int          poke_idx;
    logic [63:0] poke_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM device model: read data appears the cycle after ram_en, writes honour the bit mask.
    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_idx] <= poke_val;
        end else if (ram_en) begin
            beatq.push_back('{ram_idx, ram_we, ram_wdata, ram_wmask});
            if (ram_idx < 64'(NWORDS)) begin
                ram_rdata <= ram[ram_idx[3:0]];
                if (ram_we)
                    ram[ram_idx[3:0]] <= (ram[ram_idx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
            end else begin
                ram_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end
    end

    // Monitor: every ack pops the oldest expectation; outside acks the response outputs must be quiet.
    always @(negedge clk) begin
        if (!rst && (if_ack || d_ack)) begin
            if (if_ack && d_ack) begin
                chk("dual_ack", {63'd0, if_ack & d_ack}, 64'd0);
            end else if (expq.size() == 0) begin
                chk("unexpected_ack", 64'(expq.size()), 64'd1);
            end else begin
                mon_e = expq.pop_front();
                chk("ack_port", {63'd0, d_ack}, {63'd0, mon_e.is_d});
                chk("ack_rdata", d_ack ? d_rdata : {32'd0, if_rdata}, mon_e.rdata);
                chk("ack_err", {63'd0, d_ack ? d_err : if_err}, {63'd0, mon_e.err});
                chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else if (!rst) begin
            chk("quiet_out", d_rdata | {32'd0, if_rdata} | {62'd0, d_err, if_err}, 64'd0);
        end
    end

    task automatic poke(input int i, input logic [63:0] v);
        poke_idx = i; poke_val = v; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
        for (int b = 0; b < 8; b++) refb[i*8 + b] = v[8*b +: 8];
    endtask

    // Reference behaviour from byte-level memory semantics.
    task automatic predict(input bit is_d, input bit we, input logic [63:0] a, input logic [2:0] f3,
                           input logic [63:0] wd, output exp_t e, output int lat);
        int sz, off;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        e.is_d = is_d; e.rdata = 64'd0; e.err = 1'b0;
        if (a < BASE || (a + 64'(sz) - 64'd1) >= BASE + 64'(NWORDS*8)) begin
            e.err = 1'b1;
            lat = 1;
        end else begin
            off = int'(a - BASE);
            lat = ((off % 8) + sz > 8) ? 3 : 2;
            if (we) begin
                for (int i = 0; i < sz; i++) refb[off + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = refb[off + i];
                if (!f3[2] && v[8*sz - 1])
                    for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
    endtask

    // Called just after a clock edge with the DUT idle; returns at the same phase once all acks arrived.
    task automatic issue(input bit en_if, input logic [63:0] ia, input bit en_d, input bit we,
                         input logic [63:0] da, input logic [2:0] f3, input logic [63:0] wd);
        exp_t e1, e2;
        int   l1, l2, c0, budget;
        bit   first_d, p_if, p_d, g_if, g_d;
        c0 = cyc;
        first_d = (en_if && en_d) ? !lg_d_last : en_d;
        if (first_d) predict(1'b1, we, da, f3, wd, e1, l1);
        else         predict(1'b0, 1'b0, ia, 3'b110, 64'd0, e1, l1);
        e1.cyc = c0 + l1;
        expq.push_back(e1);
        lg_d_last = first_d;
        if (en_if && en_d) begin
            if (first_d) predict(1'b0, 1'b0, ia, 3'b110, 64'd0, e2, l2);
            else         predict(1'b1, we, da, f3, wd, e2, l2);
            e2.cyc = e1.cyc + 1 + l2;
            expq.push_back(e2);
            lg_d_last = !first_d;
        end
        if_req = en_if; if_addr = ia;
        d_req = en_d; d_we = we; d_addr = da; d_funct3 = f3; d_wdata = wd;
        p_if = en_if; p_d = en_d; budget = 0;
        while ((p_if || p_d) && budget < 30) begin
            @(negedge clk);
            g_if = if_ack; g_d = d_ack;
            @(posedge clk); #1;
            if (g_if) begin if_req = 1'b0; p_if = 1'b0; end
            if (g_d)  begin d_req = 1'b0;  p_d = 1'b0;  end
            budget++;
        end
        if (p_if || p_d) begin
            chk("txn_timeout", {62'd0, p_if, p_d}, 64'd0);
            if_req = 1'b0; d_req = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            expq.delete();
        end
    endtask

    initial begin
        logic [63:0] wd, ia, da;
        logic [2:0]  f3;
        bit          we;
        int          mode;
        rst = 1'b1; poke_en = 1'b0; poke_idx = 0; poke_val = 64'd0;
        if_req = 1'b0; if_addr = 64'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 64'd0; d_funct3 = 3'd0; d_wdata = 64'd0;
        lg_d_last = 1'b0;
        for (int i = 0; i < NWORDS; i++) poke(i, {$urandom, $urandom});
        @(negedge clk);
        chk("reset_ram_en", {63'd0, ram_en}, 64'd0);
        chk("reset_acks", {62'd0, if_ack, d_ack}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Conflict after reset: data first, then strict alternation.
        for (int k = 0; k < 4; k++)
            issue(1'b1, BASE + 64'h20, 1'b1, 1'b0, BASE + 64'h40, 3'b011, 64'd0);

        poke(2, 64'h1122_3344_5566_7788);
        beatq.delete();
        issue(1'b0, 64'd0, 1'b1, 1'b0, BASE + 64'h10, 3'b011, 64'd0);
        chk("ld_beats", 64'(beatq.size()), 64'd1);
        if (beatq.size() == 1) chk("ld_idx", beatq[0].idx, 64'd2);

        poke(0, 64'hAABB_0000_0000_0000);
        poke(1, 64'h0000_0000_0000_8000);
        beatq.delete();
        issue(1'b0, 64'd0, 1'b1, 1'b0, BASE + 64'h6, 3'b010, 64'd0);
        chk("lw_beats", 64'(beatq.size()), 64'd2);
        if (beatq.size() == 2) begin
            chk("lw_idx0", beatq[0].idx, 64'd0);
            chk("lw_idx1", beatq[1].idx, 64'd1);
        end

        beatq.delete();
        issue(1'b0, 64'd0, 1'b1, 1'b1, BASE + 64'hF, 3'b001, 64'h0000_0000_0000_1234);
        chk("sh_beats", 64'(beatq.size()), 64'd2);
        if (beatq.size() == 2) begin
            chk("sh_idx0", beatq[0].idx, 64'd1);
            chk("sh_mask0", beatq[0].wmask, 64'hFF00_0000_0000_0000);
            chk("sh_byte7", {56'd0, beatq[0].wdata[63:56]}, 64'h34);
            chk("sh_idx1", beatq[1].idx, 64'd2);
            chk("sh_mask1", beatq[1].wmask, 64'h0000_0000_0000_00FF);
            chk("sh_byte0", {56'd0, beatq[1].wdata[7:0]}, 64'h12);
        end

        beatq.delete();
        issue(1'b0, 64'd0, 1'b1, 1'b0, 64'h0000_0000_7FFF_FFF8, 3'b011, 64'd0);
        chk("fault_no_beat", 64'(beatq.size()), 64'd0);

        // Reset during the second beat of a crossing store.
        beatq.delete();
        d_req = 1'b1; d_we = 1'b1; d_addr = BASE + 64'h1C; d_funct3 = 3'b011; d_wdata = {$urandom, $urandom};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("b2_en", {63'd0, ram_en}, 64'd1);
        chk("b2_idx", ram_idx, 64'd4);
        rst = 1'b1;
        #1;
        chk("rst_drop_en", {62'd0, ram_en, ram_we}, 64'd0);
        chk("rst_no_ack", {63'd0, d_ack}, 64'd0);
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_partial_beats", 64'(beatq.size()), 64'd1);
        for (int i = 0; i < NWORDS*8; i++) refb[i] = ram[i/8][(i%8)*8 +: 8];
        lg_d_last = 1'b0;
        issue(1'b1, BASE + 64'h18, 1'b1, 1'b0, BASE + 64'h1C, 3'b011, 64'd0);

        for (int n = 0; n < 250; n++) begin
            mode = $urandom_range(0, 2);
            we   = $urandom_range(0, 1);
            f3   = we ? {1'b0, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 6));
            wd   = {$urandom, $urandom};
            ia   = BASE - 64'd8 + 64'($urandom_range(0, 143));
            da   = BASE - 64'd8 + 64'($urandom_range(0, 143));
            issue(mode != 1, ia, mode != 0, we, da, f3, wd);
        end

        chk("leftover_exp", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
